// File: rtl/countdown_pkg.sv
// Shared types for the countdown timer that paces tree-parity sync rounds.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } cd_state_t;

  localparam int LAPS_W = 8;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/busy/done handshake, pause, abort and auto-reload.
// tc strobes combinationally in the last RUN cycle of each period; laps counts expiries.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int size   = 5,
  parameter int length = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [size-1:0]   load_val,
  input  logic              reload_en,
  input  logic              pause,
  input  logic              abort,
  output logic [size-1:0]   count,
  output logic              busy,
  output logic              tc,
  output logic              done,
  output logic [LAPS_W-1:0] laps
);

  localparam logic [size-1:0] DEF_N = size'(length - 1);

  cd_state_t         state, nxt;
  logic [size-1:0]   reload;
  logic [size-1:0]   eff_n;
  logic              accept;
  logic              at_zero;

  // load_val of 0 selects the default period
  assign eff_n   = (load_val == '0) ? DEF_N : load_val;
  assign accept  = (state == IDLE) && start && !abort;
  assign at_zero = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (accept) nxt = RUN;
      RUN: begin
        if (abort)                      nxt = IDLE;
        else if (pause)                 nxt = PAUSE;
        else if (at_zero && !reload_en) nxt = DONE;
      end
      PAUSE: begin
        if (abort)       nxt = IDLE;
        else if (!pause) nxt = RUN;
      end
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == PAUSE);
    done = (state == DONE) && !abort;
    tc   = (state == RUN) && at_zero && !pause && !abort;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (abort) begin
      count <= '0;
    end else begin
      unique case (state)
        IDLE:  count <= accept ? eff_n : '0;
        RUN: begin
          if (pause)        count <= count;
          else if (at_zero) count <= reload_en ? reload : '0;
          else              count <= count - 1'b1;
        end
        PAUSE: count <= count;
        DONE:  count <= '0;
        default: count <= '0;
      endcase
    end
  end

  // reload only follows an accepted start, so mid-run starts cannot disturb it
  always_ff @(posedge clk) begin
    if (rst)         reload <= '0;
    else if (accept) reload <= eff_n;
  end

  always_ff @(posedge clk) begin
    if (rst)         laps <= '0;
    else if (accept) laps <= '0;
    else if (tc)     laps <= laps + 1'b1;
  end

endmodule
